// File: rtl/multiplexer_pkg.sv
// Shared constants and types for the one-of-eight registered selector.
package multiplexer_pkg;

    localparam int NUM_INPUTS = 8;
    localparam int SEL_W      = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : multiplexer_pkg

// File: rtl/multiplexer_mux8_comb.sv
// Purely combinational 8:1 selector; every select code maps to exactly one input.
module mux8_comb
    import multiplexer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] d_arr [NUM_INPUTS];
    logic [NUM_INPUTS*WIDTH-1:0] d_flat;

    assign d_flat = {d7, d6, d5, d4, d3, d2, d1, d0};

    // Array form keeps the decode total: an 8-entry array indexed by a 3-bit select has no out-of-range code.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
        assign d_arr[gi] = d_flat[gi*WIDTH +: WIDTH];
    end

    assign y = d_arr[sel];

endmodule : mux8_comb

// File: rtl/multiplexer.sv
// One-of-eight selector with a registered output and a one-cycle fresh-sample flag.
module multiplexer
    import multiplexer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] mux_sel;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    mux8_comb #(.WIDTH(WIDTH)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7),
        .sel (sel),
        .y   (mux_sel)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (en) begin
            out_d   = mux_sel;
            valid_d = 1'b1;
        end
    end

    // Reset wins over enable, so a sample pending on the same edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// Directed bench for the registered 8:1 selector at WIDTH=1 and WIDTH=8, scoreboard-checked.
module tb_multiplexer;

    typedef struct {
        logic [7:0] val;
        logic       valid;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic       rst1, en1;
    logic [7:0] dv1;
    logic [2:0] sel1;
    logic [0:0] out1;
    logic       vld1;

    // WIDTH = 8 instance
    logic       rst8, en8;
    logic [7:0] d8 [8];
    logic [2:0] sel8;
    logic [7:0] out8;
    logic       vld8;

    exp_t q1[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    multiplexer #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1),
        .d0(dv1[0]), .d1(dv1[1]), .d2(dv1[2]), .d3(dv1[3]),
        .d4(dv1[4]), .d5(dv1[5]), .d6(dv1[6]), .d7(dv1[7]),
        .sel(sel1), .out(out1), .out_valid(vld1)
    );

    multiplexer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8),
        .d0(d8[0]), .d1(d8[1]), .d2(d8[2]), .d3(d8[3]),
        .d4(d8[4]), .d5(d8[5]), .d6(d8[6]), .d7(d8[7]),
        .sel(sel8), .out(out8), .out_valid(vld8)
    );

    // Drive one edge's worth of inputs on the falling edge and queue what the next rising edge must produce.
    task automatic step1(input logic r, input logic e, input logic [7:0] d, input logic [2:0] s,
                         input logic exp_o, input logic exp_v, input string nm);
        exp_t x;
        @(negedge clk);
        rst1 = r; en1 = e; dv1 = d; sel1 = s;
        x.val = {7'd0, exp_o}; x.valid = exp_v; x.name = nm;
        q1.push_back(x);
    endtask

    task automatic step8(input logic r, input logic e, input logic [2:0] s,
                         input logic [7:0] exp_o, input logic exp_v, input string nm);
        exp_t x;
        @(negedge clk);
        rst8 = r; en8 = e; sel8 = s;
        x.val = exp_o; x.valid = exp_v; x.name = nm;
        q8.push_back(x);
    endtask

    initial begin : mon1
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                x = q1.pop_front();
                n_tests++;
                if (out1 !== x.val[0] || vld1 !== x.valid) begin
                    n_fail++;
                    $display("FAIL w1 %s: out=%b out_valid=%b, expected out=%b out_valid=%b",
                             x.name, out1, vld1, x.val[0], x.valid);
                end else begin
                    $display("[TB] ok w1 %s: out=%b out_valid=%b", x.name, out1, vld1);
                end
            end
        end
    end

    initial begin : mon8
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                x = q8.pop_front();
                n_tests++;
                if (out8 !== x.val || vld8 !== x.valid) begin
                    n_fail++;
                    $display("FAIL w8 %s: out=%h out_valid=%b, expected out=%h out_valid=%b",
                             x.name, out8, vld8, x.val, x.valid);
                end else begin
                    $display("[TB] ok w8 %s: out=%h out_valid=%b", x.name, out8, vld8);
                end
            end
        end
    end

    initial begin : stim
        rst1 = 1'b1; en1 = 1'b1; dv1 = 8'hFF; sel1 = 3'd0;
        rst8 = 1'b1; en8 = 1'b1; sel8 = 3'd0;
        for (int k = 0; k < 8; k++) d8[k] = 8'h10 + 8'(k);

        // Reset with all inputs high, then release into a cleared capture
        step1(1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, "reset_a");
        step1(1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, "reset_b");
        step1(1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, "post_reset");

        // Directed patterns {d7..d0}
        step1(1'b0, 1'b1, 8'b1011_0000, 3'd5, 1'b1, 1'b1, "pat_sel5");
        step1(1'b0, 1'b1, 8'b0011_1001, 3'd3, 1'b1, 1'b1, "pat_sel3");
        step1(1'b0, 1'b1, 8'b0001_1010, 3'd6, 1'b0, 1'b1, "pat_sel6");
        step1(1'b0, 1'b1, 8'b1110_0011, 3'd2, 1'b0, 1'b1, "pat_sel2");

        // Walking one across every input and every select code
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                step1(1'b0, 1'b1, 8'(1 << k), 3'(s), (k == s), 1'b1,
                      $sformatf("walk_k%0d_s%0d", k, s));
            end
        end

        // Hold with enable low, then reset beating enable
        step1(1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, "hold_load");
        step1(1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, "hold_a");
        step1(1'b0, 1'b0, 8'hF7, 3'd3, 1'b1, 1'b0, "hold_b");
        step1(1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, "rst_over_en");
        step1(1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, "idle_after_rst");
        step1(1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, "recover_sel7");

        // WIDTH = 8 back-to-back sweep
        step8(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, "w8_reset");
        for (int s = 0; s < 8; s++)
            step8(1'b0, 1'b1, 3'(s), 8'h10 + 8'(s), 1'b1, $sformatf("w8_sweep_s%0d", s));
        step8(1'b0, 1'b0, 3'd2, 8'h17, 1'b0, "w8_hold");
        step8(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, "w8_rst_over_en");

        repeat (3) @(posedge clk);
        #2;
        if (q1.size() != 0 || q8.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: leftover expectations w1=%0d w8=%0d, expected 0", q1.size(), q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_multiplexer
